instr_mem_loadable: RTL and testbench

Parametrised, loadable instruction memory for the MIPS-style pipeline fetch stage. A word-streaming loader port fills the memory after reset, so programs no longer have to be built into the RTL. The fetch port takes a byte address and returns one registered instruction word per cycle, with stall-hold, range checking and alignment checking. The block sits between the PC register and the IF/ID pipeline register.

---
 rtl/instr_mem_loadable_pkg.sv | 18 +
 rtl/instr_mem_loadable_array.sv | 33 +++
 rtl/instr_mem_loadable.sv | 155 +++++++++++++++
 tb/tb_instr_mem_loadable.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loadable_pkg.sv
// rtl/instr_mem_loadable_pkg.sv - shared types and helpers for the loadable instruction memory
// Purpose: state encoding, NOP default and byte-offset helper used by the fetch
//          stage and by the loader driver.
package instr_mem_loadable_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [63:0] NOP_WORD_DEFAULT = '0;

  // Number of byte-offset bits inside one instruction word.
  function automatic int bsh_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/instr_mem_loadable_array.sv
// rtl/instr_mem_loadable_array.sv - DEPTH x DATA_W storage, synchronous write, combinational read
// Ports:
//   clk     - clock
//   we_i    - write enable
//   waddr_i - write word index
//   wdata_i - write data
//   raddr_i - read word index
//   rdata_o - read data (combinational)
module instr_mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - loadable instruction memory with registered fetch port
// Purpose: a streaming loader fills the memory after reset (LOAD); afterwards (RUN)
//          byte-addressed fetches return one registered word per cycle with
//          stall-hold, range checking and alignment checking.
// Ports:
//   clk, rst                                    - clock, async active-high reset
//   load_valid/load_ready/load_data/load_last   - loader beat handshake
//   reload                                      - restart loading (RUN only)
//   fetch_en/fetch_addr/stall                   - fetch request, byte address, hold
//   instruction/instr_valid/addr_fault          - registered fetch result
//   mem_ready/load_count/load_overflow          - loader status
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 32,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
  localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic              mem_ready,
  output logic [CNT_W-1:0]  load_count,
  output logic              load_overflow
);

  localparam int BSH   = bsh_of(DATA_W);
  localparam int AW    = $clog2(DEPTH);
  localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << BSH) - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              out_of_range;

  assign idx          = fetch_addr >> BSH;
  assign misaligned   = |(fetch_addr & OFF_MASK);
  // Compare in a common width so indices beyond the array still fault.
  assign out_of_range = CMP_W'(idx) >= CMP_W'(cnt_q);

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (load_data),
    .raddr_i (idx[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    mem_we  = 1'b0;
    case (state_q)
      LOAD: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        fault_d = 1'b0;
        if (load_valid) begin
          if (cnt_q < CNT_W'(DEPTH)) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (load_last) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (reload) begin
          state_d = LOAD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else if (stall) begin
          // Hold the current output.
        end else if (fetch_en) begin
          if (misaligned || out_of_range) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b1;
          end else begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
            fault_d = 1'b0;
          end
        end else begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign load_ready    = (state_q == LOAD);
  assign mem_ready     = (state_q == RUN);
  assign load_count    = cnt_q;
  assign load_overflow = ovf_q;
  assign instruction   = instr_q;
  assign instr_valid   = valid_q;
  assign addr_fault    = fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - scoreboard testbench for instr_mem_loadable
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        reload = 1'b0;
  logic        fetch_en = 1'b0;
  logic [7:0]  fetch_addr = '0;
  logic        stall = 1'b0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        addr_fault;
  logic        mem_ready;
  logic [5:0]  load_count;
  logic        load_overflow;

  instr_mem_loadable #(
    .DATA_W (16),
    .DEPTH  (32),
    .ADDR_W (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_last     (load_last),
    .reload        (reload),
    .fetch_en      (fetch_en),
    .fetch_addr    (fetch_addr),
    .stall         (stall),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .addr_fault    (addr_fault),
    .mem_ready     (mem_ready),
    .load_count    (load_count),
    .load_overflow (load_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic        valid;
    logic        fault;
    logic        mready;
    logic        lready;
    logic [5:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: program held as an array of words plus a word count.
  logic [15:0] m_mem [32];
  int          m_cnt = 0;
  bit          m_run = 0;
  bit          m_ovf = 0;
  logic [15:0] m_instr = '0;
  bit          m_valid = 0;
  bit          m_fault = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit lv, input logic [15:0] ld, input bit ll,
                            input bit rl, input bit fe, input logic [7:0] fa, input bit st);
    int idx;
    if (r) begin
      m_run = 0; m_cnt = 0; m_ovf = 0;
      m_instr = '0; m_valid = 0; m_fault = 0;
    end else if (!m_run) begin
      m_instr = '0; m_valid = 0; m_fault = 0;
      if (lv) begin
        if (m_cnt < 32) begin
          m_mem[m_cnt] = ld;
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
        if (ll) m_run = 1;
      end
    end else if (rl) begin
      m_run = 0; m_cnt = 0; m_ovf = 0;
      m_instr = '0; m_valid = 0; m_fault = 0;
    end else if (st) begin
      // output unchanged
    end else if (fe) begin
      idx = int'(fa) / 2;
      if ((int'(fa) % 2) != 0 || idx >= m_cnt) begin
        m_instr = '0; m_valid = 0; m_fault = 1;
      end else begin
        m_instr = m_mem[idx]; m_valid = 1; m_fault = 0;
      end
    end else begin
      m_instr = '0; m_valid = 0; m_fault = 0;
    end
  endtask

  task automatic drive(input bit r, input bit lv, input logic [15:0] ld, input bit ll,
                       input bit rl, input bit fe, input logic [7:0] fa, input bit st);
    exp_t e;
    @(negedge clk);
    rst = r; load_valid = lv; load_data = ld; load_last = ll;
    reload = rl; fetch_en = fe; fetch_addr = fa; stall = st;
    model_step(r, lv, ld, ll, rl, fe, fa, st);
    e.instr = m_instr; e.valid = m_valid; e.fault = m_fault;
    e.mready = m_run; e.lready = !m_run; e.cnt = 6'(m_cnt); e.ovf = m_ovf;
    exp_q.push_back(e);
    if (r) begin
      #1;
      check("async_rst_valid", 32'(instr_valid), 32'(m_valid));
      check("async_rst_mem_ready", 32'(mem_ready), 32'(m_run));
      check("async_rst_load_count", 32'(load_count), 32'(m_cnt));
    end
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  task automatic beat(input logic [15:0] d, input bit last);
    drive(0, 1, d, last, 0, 0, '0, 0);
  endtask

  task automatic fetch(input logic [7:0] a, input bit st);
    drive(0, 0, '0, 0, 0, 1, a, st);
  endtask

  task automatic pulse_reload();
    drive(0, 0, '0, 0, 1, 0, '0, 0);
  endtask

  // Monitor: compares the registered outputs one step after each driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instruction", 32'(instruction), 32'(e.instr));
        check("instr_valid", 32'(instr_valid), 32'(e.valid));
        check("addr_fault", 32'(addr_fault), 32'(e.fault));
        check("mem_ready", 32'(mem_ready), 32'(e.mready));
        check("load_ready", 32'(load_ready), 32'(e.lready));
        check("load_count", 32'(load_count), 32'(e.cnt));
        check("load_overflow", 32'(load_overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    int n;
    drive(1, 0, '0, 0, 0, 0, '0, 0);
    drive(1, 0, '0, 0, 0, 0, '0, 0);
    idle();

    // Basic load and fetch; fetch issued in the first RUN cycle.
    beat(16'h1111, 0);
    beat(16'h2222, 0);
    drive(0, 0, '0, 1, 1, 1, 8'h00, 0); // load_last without valid, reload in LOAD: ignored
    beat(16'h3333, 0);
    beat(16'h4444, 1);
    fetch(8'h04, 0);
    fetch(8'h06, 0);
    // Range and alignment faults.
    fetch(8'h08, 0);
    fetch(8'h03, 0);
    idle();
    // Stall holds the previous result.
    fetch(8'h00, 0);
    fetch(8'h02, 1);
    fetch(8'h02, 1);
    fetch(8'h02, 0);
    idle();

    // Overflow: 34 beats into a 32-word memory.
    pulse_reload();
    for (int i = 0; i < 34; i++) beat(16'(32'h5000 + i), i == 33);
    fetch(8'h3E, 0);
    fetch(8'h40, 0);
    fetch(8'h00, 0);

    // Reload clears overflow; new short program.
    pulse_reload();
    idle();
    beat(16'hAAAA, 0);
    idle();
    beat(16'hBBBB, 1);
    fetch(8'h02, 0);
    fetch(8'h04, 0);
    fetch(8'h00, 0);

    // Reset mid-fetch, then reset mid-load.
    fetch(8'h02, 0);
    drive(1, 0, '0, 0, 0, 1, 8'h02, 0);
    idle();
    beat(16'h0C0C, 0);
    beat(16'h0D0D, 0);
    drive(1, 0, '0, 0, 0, 0, '0, 0);
    beat(16'h0E0E, 1);
    fetch(8'h02, 0);
    fetch(8'h00, 0);

    // Randomised load/fetch rounds.
    for (int r = 0; r < 4; r++) begin
      pulse_reload();
      n = $urandom_range(1, 36);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0)
          drive(0, 0, 16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, '0, 0);
        beat(16'($urandom), i == n - 1);
      end
      for (int i = 0; i < 60; i++) begin
        drive(0, 0, '0, 0, 0, $urandom_range(0, 3) != 0,
              8'($urandom_range(0, 2 * n + 6)), $urandom_range(0, 4) == 0);
      end
    end

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
